// File: rtl/dmem_burst_backend.sv
// Block-burst backing memory behind the L2 memory-side port: fixed-latency reads and
// merged write-backs. Optional DMEM_STATS_EN adds read/write/busy counters.
module dmem_burst_backend #(
    parameter int ADDR_BITS  = 32,
    parameter int SUB_WIDTH  = 64,
    parameter int SUBBLOCKS  = 4,
    parameter int SUB_LOG2   = 2,
    parameter int DEPTH_LOG2 = 12,
    parameter int RD_LATENCY = 8,
    parameter int WR_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 en,
    input  logic                 we,
    input  logic [SUB_LOG2-1:0]  din_strobe,
    input  logic [SUB_WIDTH-1:0] din,
    output logic [SUB_LOG2-1:0]  dout_strobe,
    output logic [SUB_WIDTH-1:0] dout,
    output logic                 ready,
    output logic                 acc_r,
    output logic                 acc_w
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]          stat_reads,
    output logic [31:0]          stat_writes,
    output logic [31:0]          stat_busy
`endif
);
    localparam int OFF   = $clog2(SUBBLOCKS * SUB_WIDTH / 8);
    localparam int BLK_W = SUB_WIDTH * SUBBLOCKS;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_COLLECT, S_WR_WAIT, S_RD_WAIT, S_RD_BURST
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [BLK_W-1:0]      r_wbuf;
    logic [BLK_W-1:0]      r_mem [2**DEPTH_LOG2];
    logic [SUB_WIDTH-1:0]  r_dout;
    logic [SUB_LOG2-1:0]   r_dout_strobe;
    logic                  r_ready;
    logic                  r_acc;

    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_accept;
    logic                  w_commit;
    logic [BLK_W-1:0]      w_blk_src;
    logic [BLK_W-1:0]      w_wbuf_next;
    logic [BLK_W-1:0]      w_rd_blk;
    logic [SUB_LOG2-1:0]   w_next_strobe;
    logic [SUB_WIDTH-1:0]  w_rd_next;
    logic                  w_unused_addr;

    assign w_idx         = addr[OFF+DEPTH_LOG2-1:OFF];
    assign w_unused_addr = ^{addr[ADDR_BITS-1:OFF+DEPTH_LOG2], addr[OFF-1:0]};
    assign w_accept      = (r_state == S_IDLE) && r_acc && en;
    assign w_commit      = reset && (r_state == S_WR_COLLECT) && (r_cnt == CNT_W'(SUBBLOCKS - 1));

    // Write buffer starts from the stored block so unwritten slots survive the write-back.
    always_comb begin
        w_blk_src   = (r_state == S_IDLE) ? r_mem[w_idx] : r_wbuf;
        w_wbuf_next = w_blk_src;
        w_wbuf_next[int'(din_strobe) * SUB_WIDTH +: SUB_WIDTH] = din;
    end

    assign w_rd_blk      = r_mem[r_idx];
    assign w_next_strobe = (r_state == S_RD_BURST) ? r_dout_strobe + 1'b1 : '0;
    assign w_rd_next     = w_rd_blk[int'(w_next_strobe) * SUB_WIDTH +: SUB_WIDTH];

    always_ff @(posedge clk) begin
        if (w_commit) r_mem[r_idx] <= w_wbuf_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_dout        <= '0;
            r_dout_strobe <= '0;
            r_ready       <= 1'b0;
            r_acc         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    r_acc   <= 1'b1;
                    if (w_accept) begin
                        r_idx <= w_idx;
                        r_acc <= 1'b0;
                        if (we) begin
                            r_wbuf  <= w_wbuf_next;
                            r_cnt   <= CNT_W'(1);
                            r_state <= S_WR_COLLECT;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= S_RD_WAIT;
                        end
                    end
                end
                S_WR_COLLECT: begin
                    r_wbuf <= w_wbuf_next;
                    if (r_cnt == CNT_W'(SUBBLOCKS - 1)) begin
                        r_cnt   <= '0;
                        r_ready <= (WR_LATENCY == 1);
                        r_state <= S_WR_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WR_WAIT: begin
                    if (r_cnt == CNT_W'(WR_LATENCY - 1)) begin
                        r_ready <= 1'b0;
                        r_acc   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_ready <= (r_cnt + 1'b1 == CNT_W'(WR_LATENCY - 1));
                    end
                end
                S_RD_WAIT: begin
                    if (r_cnt == CNT_W'(RD_LATENCY - 1)) begin
                        r_cnt         <= '0;
                        r_dout        <= w_rd_next;
                        r_dout_strobe <= '0;
                        r_ready       <= (SUBBLOCKS == 1);
                        r_state       <= S_RD_BURST;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RD_BURST: begin
                    if (r_dout_strobe == SUB_LOG2'(SUBBLOCKS - 1)) begin
                        r_dout        <= '0;
                        r_dout_strobe <= '0;
                        r_ready       <= 1'b0;
                        r_acc         <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_dout        <= w_rd_next;
                        r_dout_strobe <= w_next_strobe;
                        r_ready       <= (w_next_strobe == SUB_LOG2'(SUBBLOCKS - 1));
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dout        = r_dout;
    assign dout_strobe = r_dout_strobe;
    assign ready       = r_ready;
    assign acc_r       = r_acc;
    assign acc_w       = r_acc;

`ifdef DMEM_STATS_EN
    logic [31:0] r_stat_reads;
    logic [31:0] r_stat_writes;
    logic [31:0] r_stat_busy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stat_reads  <= '0;
            r_stat_writes <= '0;
            r_stat_busy   <= '0;
        end else begin
            if (w_accept && !we) r_stat_reads  <= r_stat_reads + 1'b1;
            if (w_accept && we)  r_stat_writes <= r_stat_writes + 1'b1;
            if (r_state != S_IDLE) r_stat_busy <= r_stat_busy + 1'b1;
        end
    end

    assign stat_reads  = r_stat_reads;
    assign stat_writes = r_stat_writes;
    assign stat_busy   = r_stat_busy;
`endif
endmodule
